multiplier_booths_feeder: RTL and testbench

Operand-queueing front end for the Booth shift-add multiplier. Accepts operand pairs over a valid/ready handshake, buffers them in a small FIFO, and launches one multiplication at a time with a single-cycle `load` pulse. It holds the operands stable for the whole multiplication, captures the product on the first `done`, and presents it on a valid/ready output port. It sits directly upstream of the multiplier and also terminates its result path.

---
 rtl/multiplier_booths_feeder.sv | 145 ++++++++++++++
 tb/tb_multiplier_booths_feeder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_booths_feeder.sv
// Operand FIFO and launch/capture sequencer for the Booth shift-add multiplier.
// One operation in flight; the result is held on a valid/ready port until taken.
module multiplier_booths_feeder #(
  parameter int width = 8,
  parameter int depth = 4,
  parameter int aw    = 2,
  parameter int tw    = 5
) (
  input  logic                 clock,
  input  logic                 clear_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [width-1:0]     in_multiplier,
  input  logic [width-1:0]     in_multiplicand,
  output logic                 mul_load,
  output logic [width-1:0]     mul_multiplier,
  output logic [width-1:0]     mul_multiplicand,
  input  logic                 mul_done,
  input  logic [2*width-1:0]   mul_product,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*width-1:0]   out_product,
  output logic                 busy,
  output logic                 err,
  output logic [1:0]           fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never depends on ready, and in_ready depends only on occupancy.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam int cw = aw + 1;
  localparam logic [tw-1:0] timer_last = tw'(2 * width - 1);

  state_t state, next_state;

  logic [width-1:0] mem_a [depth];
  logic [width-1:0] mem_b [depth];
  logic [aw-1:0]    wr_ptr, rd_ptr;
  logic [cw-1:0]    count;
  logic [tw-1:0]    timer;
  logic             full, empty, push, pop;
  logic             capture, timeout, ack;

  assign full      = (count == cw'(depth));
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign push      = in_valid && !full;
  assign fsm_state = state;

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    capture    = 1'b0;
    timeout    = 1'b0;
    ack        = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          next_state = S_LOAD;
        end
      end
      // mul_done is not looked at here: a stale high is cleared by the load edge.
      S_LOAD: next_state = S_WAIT;
      S_WAIT: begin
        if (mul_done) begin
          capture    = 1'b1;
          next_state = S_HOLD;
        end else if (timer == timer_last) begin
          timeout    = 1'b1;
          next_state = S_IDLE;
        end
      end
      S_HOLD: begin
        if (out_valid && out_ready) begin
          ack        = 1'b1;
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_a[wr_ptr] <= in_multiplier;
      mem_b[wr_ptr] <= in_multiplicand;
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + aw'(1);
      if (pop)  rd_ptr <= rd_ptr + aw'(1);
      case ({push, pop})
        2'b10:   count <= count + cw'(1);
        2'b01:   count <= count - cw'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state            <= S_IDLE;
      mul_load         <= 1'b0;
      mul_multiplier   <= '0;
      mul_multiplicand <= '0;
      timer            <= '0;
      out_valid        <= 1'b0;
      out_product      <= '0;
      err              <= 1'b0;
      busy             <= 1'b0;
    end else begin
      state    <= next_state;
      mul_load <= pop;
      busy     <= (state != S_IDLE) || !empty;
      if (pop) begin
        mul_multiplier   <= mem_a[rd_ptr];
        mul_multiplicand <= mem_b[rd_ptr];
      end
      if (state == S_LOAD)      timer <= '0;
      else if (state == S_WAIT) timer <= timer + tw'(1);
      if (capture) begin
        out_product <= mul_product;
        out_valid   <= 1'b1;
      end else if (ack) begin
        out_valid <= 1'b0;
      end
      if (timeout) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multiplier_booths_feeder.sv
// Bench for multiplier_booths_feeder: directed scenarios plus random traffic,
// with a fixed-latency signed multiplier stand-in and an in-order product scoreboard.
module tb_multiplier_booths_feeder;
  localparam int W = 8;

  logic           clock = 1'b0;
  logic           clear_n, in_valid, in_ready, mul_load, mul_done;
  logic           out_valid, out_ready, busy, err;
  logic [W-1:0]   in_multiplier, in_multiplicand, mul_multiplier, mul_multiplicand;
  logic [2*W-1:0] mul_product, out_product;
  logic [1:0]     fsm_state;

  multiplier_booths_feeder #(.width(W), .depth(4), .aw(2), .tw(5)) dut (
    .clock(clock), .clear_n(clear_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_multiplier(in_multiplier), .in_multiplicand(in_multiplicand),
    .mul_load(mul_load), .mul_multiplier(mul_multiplier),
    .mul_multiplicand(mul_multiplicand), .mul_done(mul_done),
    .mul_product(mul_product), .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .busy(busy), .err(err), .fsm_state(fsm_state)
  );

  always #5 clock = ~clock;

  int tests = 0, fails = 0;
  int cyc = 0, loads = 0, load_cyc = 0, outs = 0, drops = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] got_q[$];
  int hs_cyc[$];
  bit done_en = 1'b1;

  function automatic logic [2*W-1:0] smul(input logic [W-1:0] a, input logic [W-1:0] b);
    int ia, ib;
    ia = int'($signed(a));
    ib = int'($signed(b));
    return 16'(ia * ib);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(posedge clock) cyc++;

  // Multiplier stand-in: done rises W+1 edges after the load edge unless disabled.
  int  mcnt;
  bit  mact;
  always @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      mul_done <= 1'b0; mact <= 1'b0; mcnt <= 0; mul_product <= '0;
    end else if (mul_load) begin
      mul_done <= 1'b0; mact <= 1'b1; mcnt <= 0;
      mul_product <= smul(mul_multiplier, mul_multiplicand);
    end else if (mact) begin
      mcnt <= mcnt + 1;
      if (mcnt + 1 == W + 1 && done_en) begin
        mul_done <= 1'b1; mact <= 1'b0;
      end
    end
  end

  // Monitor at the falling edge: everything seen here transfers on the next rising edge.
  logic [2*W-1:0] prev_prod;
  bit prev_stall = 1'b0, prev_err = 1'b0;
  always @(negedge clock) begin
    if (clear_n) begin
      if (in_valid && in_ready) exp_q.push_back(smul(in_multiplier, in_multiplicand));
      if (mul_load) begin loads++; load_cyc = cyc + 1; end
      if (prev_stall) begin
        check("hold_product_stable", out_product, prev_prod);
        check("hold_valid_stable", out_valid, 1);
      end
      if (out_valid && out_ready) begin
        outs++;
        got_q.push_back(out_product);
        hs_cyc.push_back(cyc + 1);
        check("result_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("product", out_product, exp_q.pop_front());
      end
      if (err && !prev_err) begin
        drops++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev_prod  = out_product;
      prev_err   = err;
    end else begin
      prev_stall = 1'b0;
      prev_err   = 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, output bit acc);
    in_valid = 1'b1; in_multiplier = a; in_multiplicand = b;
    acc = in_ready;
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic push_wait(input logic [W-1:0] a, input logic [W-1:0] b);
    bit acc;
    int n = 0;
    do begin push(a, b, acc); n++; end while (!acc && n < 200);
    check("push_accepted", acc, 1);
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < maxc) begin step(1); n++; end
    check("drained", exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mul_load"}, mul_load, 0);
    check({tag, "_mul_multiplier"}, mul_multiplier, 0);
    check({tag, "_mul_multiplicand"}, mul_multiplicand, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_product"}, out_product, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_in_ready"}, in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n, l0, g0, h0, d0;
    logic [W-1:0] ra, rb;
    logic [2*W-1:0] stream_exp [4];
    stream_exp[0] = 16'hFFF1; stream_exp[1] = 16'h0009;
    stream_exp[2] = 16'h0000; stream_exp[3] = 16'h0001;

    clear_n = 1'b0; in_valid = 1'b0; in_multiplier = '0; in_multiplicand = '0;
    out_ready = 1'b0;
    step(3);
    check_all_zero("reset");
    clear_n = 1'b1;
    step(2);

    // Single operation and idle latency.
    out_ready = 1'b1;
    l0 = loads;
    push(8'd7, 8'd9, acc);
    check("single_accept", acc, 1);
    n = 0;
    while (!out_valid && n < 40) begin step(1); n++; end
    check("single_latency", n, W + 4);
    check("single_product", out_product, 16'h003F);
    check("single_err", err, 0);
    step(3);
    check("single_load_count", loads - l0, 1);
    check("single_consumed", exp_q.size(), 0);

    // Fill: five accepted, sixth ignored, result held without a new load.
    out_ready = 1'b0;
    l0 = loads;
    for (int i = 0; i < 6; i++) begin
      push(W'(i + 1), W'(i + 2), acc);
      if (i < 5) check("fill_accept", acc, 1);
      else       check("fill_sixth_ignored", acc, 0);
    end
    check("fill_in_ready_low", in_ready, 0);
    step(20);
    check("fill_single_load", loads - l0, 1);
    check("fill_held_valid", out_valid, 1);
    check("fill_busy", busy, 1);
    drain(200);

    // Stream with ready held high: ordered results, 13-cycle spacing.
    out_ready = 1'b1;
    g0 = got_q.size();
    h0 = hs_cyc.size();
    push_wait(8'hFD, 8'd5);
    push_wait(8'd3, 8'd3);
    push_wait(8'd0, 8'd255);
    push_wait(8'd255, 8'd255);
    drain(200);
    check("stream_count", got_q.size() - g0, 4);
    if (got_q.size() >= g0 + 4 && hs_cyc.size() >= h0 + 4) begin
      for (int k = 0; k < 4; k++) check("stream_product", got_q[g0 + k], stream_exp[k]);
      for (int k = 0; k < 3; k++) check("stream_spacing", hs_cyc[h0 + k + 1] - hs_cyc[h0 + k], W + 5);
    end

    // Back-pressure: ready toggles every 3 cycles.
    out_ready = 1'b0;
    g0 = outs;
    for (int i = 0; i < 5; i++) push_wait(W'($urandom), W'($urandom));
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      if (n % 3 == 0) out_ready = ~out_ready;
      step(1);
      n++;
    end
    check("bp_drained", exp_q.size(), 0);
    check("bp_handshakes", outs - g0, 5);
    drain(40);

    // Random traffic with random ready and gaps.
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 3) == 0) step($urandom_range(1, 5));
      n = 0;
      do begin
        out_ready = 1'($urandom_range(0, 1));
        push(ra, rb, acc);
        n++;
      end while (!acc && n < 500);
      check("rand_accept", acc, 1);
    end
    drain(600);

    // Timeout: no done for the first op, the second op still completes.
    out_ready = 1'b1;
    done_en = 1'b0;
    d0 = drops;
    push_wait(8'd5, 8'd6);
    push_wait(8'd3, 8'd4);
    n = 0;
    while (!err && n < 60) begin step(1); n++; end
    check("timeout_err", err, 1);
    check("timeout_delay", cyc - load_cyc, 2 * W);
    done_en = 1'b1;
    drain(100);
    check("timeout_err_sticky", err, 1);
    check("timeout_one_drop", drops - d0, 1);

    // Reset in the middle of WAIT with two entries still queued.
    out_ready = 1'b0;
    push_wait(8'd11, 8'd12);
    push_wait(8'd13, 8'd14);
    push_wait(8'd15, 8'd16);
    step(4);
    clear_n = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    step(2);
    clear_n = 1'b1;
    l0 = loads;
    step(20);
    check("midreset_no_load", loads - l0, 0);
    check("midreset_idle_busy", busy, 0);
    check("midreset_no_valid", out_valid, 0);
    g0 = got_q.size();
    push_wait(8'd2, 8'd3);
    drain(60);
    check("post_reset_count", got_q.size() - g0, 1);
    if (got_q.size() > g0) check("post_reset_product", got_q[g0], 16'h0006);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
